multicycle_processor: RTL

Multicycle MIPS32-subset core, the next generation of the team's single-cycle processor. It uses one shared memory port for both instruction fetch and data access, with a req/ready wait-state handshake. Execution is sequenced by an FSM. Packed-add lane width is parametrised, and the core adds bne, j, signed slt, and an illegal-instruction halt.

---
 rtl/multicycle_processor.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_processor.sv
// Multicycle MIPS32-subset core. A single memory port is shared by fetch and
// data access. A six-state FSM (FETCH, DECODE, EXEC, MEM, WB, HALT) sequences
// each instruction.
//
// Memory handshake: while mem_req=1 the core holds mem_addr, mem_we and
// mem_wdata stable. A transaction completes on the rising edge where
// mem_req=1 and mem_ready=1. mem_rdata is only taken on that edge.
module multicycle_processor #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          LANE_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] PC,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        halted
);

  localparam int LANES = 32 / LANE_W;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_JR    = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_PADD  = 6'b011111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_PADD = 6'b010000;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      state, state_next;
  logic [31:0] ir, a_reg, b_reg, alu_out, mdr;
  logic [31:0] regs [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt, dest;
  logic [31:0] simm, pc_plus4, alu_result, wb_data;
  logic [31:0] pk_wrap, pk_sat;
  logic        legal, is_mem, is_sw, is_ctrl, taken;

  if (LANE_W != 8 && LANE_W != 16) begin : g_bad_lane
    $error("multicycle_processor: LANE_W must be 8 or 16");
  end

  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign shamt    = ir[10:6];
  assign funct    = ir[5:0];
  assign simm     = {{16{ir[15]}}, ir[15:0]};
  assign pc_plus4 = PC + 32'd4;
  assign is_sw    = (op == OP_SW);
  assign is_mem   = (op == OP_LW) || is_sw;
  assign is_ctrl  = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J) ||
                    (op == OP_JAL) || (op == OP_JR);
  assign taken    = ((op == OP_BEQ) && (a_reg == b_reg)) ||
                    ((op == OP_BNE) && (a_reg != b_reg));
  assign dest     = ((op == OP_RTYPE) || (op == OP_PADD)) ? rd : rt;
  assign wb_data  = (op == OP_LW) ? mdr : alu_out;
  assign halted   = (state == S_HALT);

  // Packed add lanes: each lane adds on its own, so no carry crosses lanes.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LANE_W:0] sum;
    assign sum = {1'b0, a_reg[i*LANE_W +: LANE_W]} + {1'b0, b_reg[i*LANE_W +: LANE_W]};
    assign pk_wrap[i*LANE_W +: LANE_W] = sum[LANE_W-1:0];
    assign pk_sat[i*LANE_W +: LANE_W]  = sum[LANE_W] ? {LANE_W{1'b1}} : sum[LANE_W-1:0];
  end

  // Decode legality: anything not listed here halts the core.
  always_comb begin
    legal = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLLV, F_SRLV, F_SRAV: legal = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_JR: legal = 1'b1;
      OP_PADD: legal = (funct == F_PADD) && ((shamt == 5'd0) || (shamt == 5'd4));
      default: legal = 1'b0;
    endcase
  end

  // ALU: addi/lw/sw use rs + simm; R-type and packed ops use A and B.
  always_comb begin
    alu_result = a_reg + simm;
    if (op == OP_RTYPE) begin
      case (funct)
        F_ADD:   alu_result = a_reg + b_reg;
        F_SUB:   alu_result = a_reg - b_reg;
        F_AND:   alu_result = a_reg & b_reg;
        F_OR:    alu_result = a_reg | b_reg;
        F_SLT:   alu_result = {31'd0, $signed(a_reg) < $signed(b_reg)};
        F_SLLV:  alu_result = b_reg << a_reg[4:0];
        F_SRLV:  alu_result = b_reg >> a_reg[4:0];
        F_SRAV:  alu_result = $unsigned($signed(b_reg) >>> a_reg[4:0]);
        default: alu_result = a_reg + b_reg;
      endcase
    end else if (op == OP_PADD) begin
      alu_result = (shamt == 5'd4) ? pk_sat : pk_wrap;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_next;
  end

  // FSM next state and memory port drive; reset forces the port quiet.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = PC;
    mem_wdata  = 32'd0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: state_next = legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_mem)       state_next = S_MEM;
        else if (is_ctrl) state_next = S_FETCH;
        else              state_next = S_WB;
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_addr  = alu_out;
        mem_we    = is_sw;
        mem_wdata = is_sw ? b_reg : 32'd0;
        if (mem_ready) state_next = is_sw ? S_FETCH : S_WB;
      end
      S_WB:    state_next = S_FETCH;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_HALT;
    endcase
    if (!reset) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = 32'd0;
    end
  end

  // Datapath registers, PC and register file. Reset blocks every register
  // write, so an interrupted transaction leaves no trace.
  always_ff @(posedge clk) begin
    if (!reset) begin
      PC <= RESET_PC;
    end else begin
      case (state)
        S_FETCH: if (mem_ready) ir <= mem_rdata;
        S_DECODE: begin
          a_reg <= (rs == 5'd0) ? 32'd0 : regs[rs];
          b_reg <= (rt == 5'd0) ? 32'd0 : regs[rt];
        end
        S_EXEC: begin
          alu_out <= alu_result;
          case (op)
            OP_BEQ, OP_BNE: PC <= taken ? pc_plus4 + {simm[29:0], 2'b00} : pc_plus4;
            OP_J:           PC <= {pc_plus4[31:28], ir[25:0], 2'b00};
            OP_JAL: begin
              PC       <= {pc_plus4[31:28], ir[25:0], 2'b00};
              regs[31] <= pc_plus4;
            end
            OP_JR:          PC <= a_reg;
            default: ;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (is_sw) PC  <= pc_plus4;
            else       mdr <= mem_rdata;
          end
        end
        S_WB: begin
          if (dest != 5'd0) regs[dest] <= wb_data;
          PC <= pc_plus4;
        end
        default: ;
      endcase
    end
  end

endmodule
